// File: rtl/jedro_1_clint.sv
// jedro_1_clint: core-local interruptor.
// Holds a 64-bit machine timer (MTIME) driven by a programmable prescaler, a 64-bit
// compare register (MTIMECMP), and a one-bit software-interrupt register (MSIP).
// The bus side takes one word access per cycle and answers every request exactly
// one cycle later, with no stall. Both interrupt outputs are registered levels.
module jedro_1_clint #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int PRESCALE_WIDTH = 16,
    parameter int PRESCALE_RST   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_ro,
    output logic [DATA_WIDTH-1:0] rdata_ro,
    output logic                  err_ro,
    output logic                  timer_irq_ro,
    output logic                  sw_irq_ro
);

    // Word indices (byte offset / 4) of the register map
    localparam logic [2:0] REG_MSIP        = 3'd0;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd2;
    localparam logic [2:0] REG_MTIME_LO    = 3'd3;
    localparam logic [2:0] REG_MTIME_HI    = 3'd4;
    localparam logic [2:0] REG_PRESCALE    = 3'd5;

    // Highest valid byte offset; anything above it is an access error
    localparam logic [ADDR_WIDTH-1:0] LAST_OFFSET = ADDR_WIDTH'(20);

    // Parameter sanity: the register map and byte lanes assume a 32-bit word
    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("jedro_1_clint: DATA_WIDTH must be 32");
        end
        if (ADDR_WIDTH < 5) begin : g_bad_addr_width
            $error("jedro_1_clint: ADDR_WIDTH must be at least 5");
        end
        if ((PRESCALE_WIDTH < 1) || (PRESCALE_WIDTH > DATA_WIDTH)) begin : g_bad_prescale_width
            $error("jedro_1_clint: PRESCALE_WIDTH must be in 1..DATA_WIDTH");
        end
    endgenerate

    // Architectural state
    logic                      msip_q, msip_d;
    logic [2*DATA_WIDTH-1:0]   mtimecmp_q, mtimecmp_d;
    logic [2*DATA_WIDTH-1:0]   mtime_q, mtime_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

    // Bus response and interrupt output registers
    logic                      rvalid_q, rvalid_d;
    logic                      err_q, err_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      timer_irq_q, timer_irq_d;
    logic                      sw_irq_q, sw_irq_d;

    // Decode helpers
    logic                      addr_ok;
    logic                      wr_en;
    logic [2:0]                reg_idx;
    logic [DATA_WIDTH-1:0]     wmask;
    logic [DATA_WIDTH-1:0]     read_word;
    logic [DATA_WIDTH-1:0]     merged_word;
    logic [5:0]                wr_sel;
    logic                      tick;

    assign reg_idx = addr_i[4:2];
    assign addr_ok = (addr_i[1:0] == 2'b00) && (addr_i <= LAST_OFFSET);
    // A write with no byte enabled is accepted but touches nothing, so it is
    // excluded here: it must neither clear the prescaler nor stall MTIME.
    assign wr_en   = req_i && we_i && addr_ok && (|be_i);
    assign tick    = (cnt_q == prescale_q);

    // Expand byte enables into a bit mask, one byte lane per enable
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{be_i[gi]}};
        end
        for (genvar gi = 0; gi < 6; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (reg_idx == 3'(gi));
        end
    endgenerate

    // Current value of the addressed register; doubles as the base for byte merges
    always_comb begin
        read_word = '0;
        case (reg_idx)
            REG_MSIP:        read_word = {{(DATA_WIDTH-1){1'b0}}, msip_q};
            REG_MTIMECMP_LO: read_word = mtimecmp_q[DATA_WIDTH-1:0];
            REG_MTIMECMP_HI: read_word = mtimecmp_q[2*DATA_WIDTH-1:DATA_WIDTH];
            REG_MTIME_LO:    read_word = mtime_q[DATA_WIDTH-1:0];
            REG_MTIME_HI:    read_word = mtime_q[2*DATA_WIDTH-1:DATA_WIDTH];
            REG_PRESCALE:    read_word = DATA_WIDTH'(prescale_q);
            default:         read_word = '0;
        endcase
    end

    assign merged_word = (read_word & ~wmask) | (wdata_i & wmask);

    // Next-state: prescaler, timer increment, register writes and bus response
    always_comb begin
        msip_d      = msip_q;
        mtimecmp_d  = mtimecmp_q;
        prescale_d  = prescale_q;
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        mtime_d     = tick ? mtime_q + 1'b1 : mtime_q;

        // Bus writes override the tick: a written MTIME half takes the merged
        // word and the other half keeps its old value, with no increment.
        if (wr_sel[REG_MSIP]) begin
            msip_d = merged_word[0];
        end
        if (wr_sel[REG_MTIMECMP_LO]) begin
            mtimecmp_d[DATA_WIDTH-1:0] = merged_word;
        end
        if (wr_sel[REG_MTIMECMP_HI]) begin
            mtimecmp_d[2*DATA_WIDTH-1:DATA_WIDTH] = merged_word;
        end
        if (wr_sel[REG_MTIME_LO]) begin
            mtime_d = {mtime_q[2*DATA_WIDTH-1:DATA_WIDTH], merged_word};
            cnt_d   = '0;
        end
        if (wr_sel[REG_MTIME_HI]) begin
            mtime_d = {merged_word, mtime_q[DATA_WIDTH-1:0]};
        end
        if (wr_sel[REG_PRESCALE]) begin
            prescale_d = merged_word[PRESCALE_WIDTH-1:0];
            cnt_d      = '0;
        end

        rvalid_d    = req_i;
        err_d       = req_i && !addr_ok;
        rdata_d     = (req_i && !we_i && addr_ok) ? read_word : '0;

        // Interrupts follow the registered state, one cycle behind it
        timer_irq_d = (mtime_q >= mtimecmp_q);
        sw_irq_d    = msip_q;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            msip_q      <= 1'b0;
            mtimecmp_q  <= '1;
            mtime_q     <= '0;
            prescale_q  <= PRESCALE_WIDTH'(PRESCALE_RST);
            cnt_q       <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            timer_irq_q <= 1'b0;
            sw_irq_q    <= 1'b0;
        end else begin
            msip_q      <= msip_d;
            mtimecmp_q  <= mtimecmp_d;
            mtime_q     <= mtime_d;
            prescale_q  <= prescale_d;
            cnt_q       <= cnt_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            timer_irq_q <= timer_irq_d;
            sw_irq_q    <= sw_irq_d;
        end
    end

    assign rvalid_ro    = rvalid_q;
    assign err_ro       = err_q;
    assign rdata_ro     = rdata_q;
    assign timer_irq_ro = timer_irq_q;
    assign sw_irq_ro    = sw_irq_q;

endmodule

// File: tb/tb_jedro_1_clint.sv
// Testbench for jedro_1_clint: reset behaviour, a table of register accesses,
// hand-written timer/prescaler/wrap/MSIP/throughput sequences, then randomized
// traffic checked against a cycle-indexed reference model.
module tb_jedro_1_clint;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_ro;
    logic [31:0] rdata_ro;
    logic        err_ro;
    logic        timer_irq_ro;
    logic        sw_irq_ro;

    int n_tests = 0;
    int n_fail  = 0;

    jedro_1_clint #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (5),
        .PRESCALE_WIDTH(16),
        .PRESCALE_RST  (0)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rvalid_ro   (rvalid_ro),
        .rdata_ro    (rdata_ro),
        .err_ro      (err_ro),
        .timer_irq_ro(timer_irq_ro),
        .sw_irq_ro   (sw_irq_ro)
    );

    always #5 clk_i = ~clk_i;

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [3:0] be, input logic [4:0] addr,
                                input logic [31:0] wdata, input logic exp_err,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.we        = we;
        v.be        = be;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_err   = exp_err;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus access; called just after a rising edge, returns just after the next
    task automatic access(input logic we, input logic [3:0] be, input logic [4:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic err, output logic vld);
        req_i   = 1'b1;
        we_i    = we;
        be_i    = be;
        addr_i  = addr;
        wdata_i = wd;
        @(posedge clk_i);
        #1;
        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'h0;
        addr_i  = 5'h0;
        wdata_i = 32'h0;
        rd  = rdata_ro;
        err = err_ro;
        vld = rvalid_ro;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] d;
        logic        e, v;
        access(1'b1, be, addr, wd, d, e, v);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e, v;
        access(1'b0, 4'hF, addr, 32'h0, d, e, v);
        check(name, {31'h0, v, d}, {31'h0, 1'b1, exp});
    endtask

    // Reference model: register contents plus a prescaler phase expressed as
    // "cycle index at which the counter last restarted from zero".
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_msip;
    longint      m_presc;
    longint      m_start;

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            0:       return {31'h0, m_msip};
            1:       return m_cmp[31:0];
            2:       return m_cmp[63:32];
            3:       return m_mtime[31:0];
            4:       return m_mtime[63:32];
            5:       return {16'h0, m_presc[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    // One random cycle (index k counted from reset release) checked against the model
    task automatic rand_cycle(input longint k);
        logic        r, w, bad, tick;
        logic [3:0]  b;
        logic [4:0]  a;
        logic [31:0] d, old, mask, merged, e_rdata;
        logic        e_err, e_tirq, e_sirq;
        logic [63:0] nxt;
        int          sel, idx;

        r   = ($urandom_range(0, 3) != 0);
        w   = ($urandom_range(0, 1) == 1);
        b   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
        sel = $urandom_range(0, 6);
        a   = (sel < 6) ? 5'(sel * 4) : 5'($urandom_range(0, 31));
        idx = int'(a[4:2]);
        if (sel == 6 || idx == 5)       d = 32'($urandom_range(0, 3));
        else if (idx == 2 || idx == 4)  d = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
        else if (idx == 1 || idx == 3)  d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 60)) : $urandom;
        else                            d = $urandom;

        req_i   = r;
        we_i    = w;
        be_i    = b;
        addr_i  = a;
        wdata_i = d;

        bad     = (a[1:0] != 2'b00) || (a > 5'h14);
        old     = m_read(idx);
        e_err   = r && bad;
        e_rdata = (r && !w && !bad) ? old : 32'h0;
        e_tirq  = (m_mtime >= m_cmp);
        e_sirq  = m_msip;

        for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{b[i]}};
        merged = (old & ~mask) | (d & mask);
        tick   = (((k - m_start) % (m_presc + 1)) == m_presc);
        nxt    = tick ? m_mtime + 64'd1 : m_mtime;
        if (r && w && !bad && (b != 4'h0)) begin
            case (idx)
                0: m_msip = merged[0];
                1: m_cmp[31:0] = merged;
                2: m_cmp[63:32] = merged;
                3: begin nxt = {m_mtime[63:32], merged}; m_start = k + 1; end
                4: nxt = {merged, m_mtime[31:0]};
                5: begin m_presc = longint'(merged[15:0]); m_start = k + 1; end
                default: ;
            endcase
        end
        m_mtime = nxt;

        @(posedge clk_i);
        #1;
        check($sformatf("rand%0d_rvalid", k), {63'h0, rvalid_ro}, {63'h0, r});
        check($sformatf("rand%0d_err", k), {63'h0, err_ro}, {63'h0, e_err});
        check($sformatf("rand%0d_rdata", k), {32'h0, rdata_ro}, {32'h0, e_rdata});
        check($sformatf("rand%0d_timer_irq", k), {63'h0, timer_irq_ro}, {63'h0, e_tirq});
        check($sformatf("rand%0d_sw_irq", k), {63'h0, sw_irq_ro}, {63'h0, e_sirq});
        req_i = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        e, v;
        int          rise;
        int          pulses;
        logic [31:0] t6_exp [4];

        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'h0;
        addr_i  = 5'h0;
        wdata_i = 32'h0;
        rst_i   = 1'b1;

        // Reset state of the outputs
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_rvalid", {63'h0, rvalid_ro}, 64'h0);
        check("rst_rdata", {32'h0, rdata_ro}, 64'h0);
        check("rst_err", {63'h0, err_ro}, 64'h0);
        check("rst_timer_irq", {63'h0, timer_irq_ro}, 64'h0);
        check("rst_sw_irq", {63'h0, sw_irq_ro}, 64'h0);
        rst_i = 1'b0;

        // T1: reset asserted while a response is on the bus drops it at once
        req_i  = 1'b1;
        addr_i = 5'h08;
        @(posedge clk_i);
        #1;
        req_i  = 1'b0;
        addr_i = 5'h0;
        check("t1_rvalid_before_rst", {63'h0, rvalid_ro}, 64'h1);
        #2 rst_i = 1'b1;
        #1;
        check("t1_rvalid_dropped", {63'h0, rvalid_ro}, 64'h0);
        check("t1_rdata_dropped", {32'h0, rdata_ro}, 64'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rd_chk("t1_mtime_lo", 5'h0C, 32'h0);
        rd_chk("t1_cmp_hi", 5'h08, 32'hFFFF_FFFF);
        check("t1_timer_irq", {63'h0, timer_irq_ro}, 64'h0);

        // Table of single accesses, applied back to back
        vecs.push_back(mk(1'b0, 4'hF, 5'h00, 32'h0,          1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h04, 32'h0,          1'b0, 32'hFFFF_FFFF));
        vecs.push_back(mk(1'b0, 4'hF, 5'h08, 32'h0,          1'b0, 32'hFFFF_FFFF));
        vecs.push_back(mk(1'b0, 4'hF, 5'h14, 32'h0,          1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h02, 32'h0,          1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h18, 32'h0,          1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h1C, 32'h0,          1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 4'hF, 5'h04, 32'h1234_5678,  1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h04, 32'h0,          1'b0, 32'h1234_5678));
        vecs.push_back(mk(1'b1, 4'h5, 5'h04, 32'hAABB_CCDD,  1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h04, 32'h0,          1'b0, 32'h12BB_56DD));
        vecs.push_back(mk(1'b1, 4'hF, 5'h18, 32'h0,          1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 4'hF, 5'h06, 32'h0,          1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h04, 32'h0,          1'b0, 32'h12BB_56DD));
        vecs.push_back(mk(1'b1, 4'h1, 5'h00, 32'hFFFF_FFFF,  1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h00, 32'h0,          1'b0, 32'h1));
        vecs.push_back(mk(1'b1, 4'h0, 5'h08, 32'h0,          1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h08, 32'h0,          1'b0, 32'hFFFF_FFFF));
        vecs.push_back(mk(1'b1, 4'h3, 5'h14, 32'hFFFF_1234,  1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h14, 32'h0,          1'b0, 32'h1234));
        vecs.push_back(mk(1'b1, 4'hC, 5'h14, 32'hABCD_0000,  1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h14, 32'h0,          1'b0, 32'h1234));
        vecs.push_back(mk(1'b1, 4'h2, 5'h14, 32'h0000_AB00,  1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 4'hF, 5'h14, 32'h0,          1'b0, 32'hAB34));
        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, d, e, v);
            check($sformatf("vec%0d_rvalid", i), {63'h0, v}, 64'h1);
            check($sformatf("vec%0d_err", i), {63'h0, e}, {63'h0, vecs[i].exp_err});
            check($sformatf("vec%0d_rdata", i), {32'h0, d}, {32'h0, vecs[i].exp_rdata});
        end

        // T2: compare at 20, timer restarted from 0 with no prescaling
        wr(5'h14, 32'h0000_FFFF, 4'hF);
        wr(5'h08, 32'h0, 4'hF);
        wr(5'h04, 32'd20, 4'hF);
        wr(5'h0C, 32'h0, 4'hF);
        wr(5'h10, 32'h0, 4'hF);
        wr(5'h14, 32'h0, 4'hF);
        wr(5'h0C, 32'h0, 4'hF);
        rise = 0;
        for (int k = 1; k <= 40 && rise == 0; k++) begin
            @(posedge clk_i);
            #1;
            if (timer_irq_ro) rise = k;
        end
        check("t2_irq_rise_cycle", 64'(rise), 64'd21);
        wr(5'h04, 32'd100, 4'hF);
        check("t2_irq_hold", {63'h0, timer_irq_ro}, 64'h1);
        @(posedge clk_i);
        #1;
        check("t2_irq_fall", {63'h0, timer_irq_ro}, 64'h0);

        // T3: divide by 4, carry from low to high half, write beats tick
        wr(5'h14, 32'd3, 4'hF);
        wr(5'h10, 32'h0, 4'hF);
        wr(5'h0C, 32'hFFFF_FFFE, 4'hF);
        repeat (8) @(posedge clk_i);
        #1;
        rd_chk("t3_carry_lo", 5'h0C, 32'h0);
        rd_chk("t3_carry_hi", 5'h10, 32'h1);
        @(posedge clk_i);
        #1;
        wr(5'h0C, 32'h55, 4'hF);
        rd_chk("t3_write_wins_lo", 5'h0C, 32'h55);
        rd_chk("t3_write_wins_hi", 5'h10, 32'h1);

        // T4: all-ones timer against all-ones compare, then wrap to zero
        wr(5'h14, 32'd1, 4'hF);
        wr(5'h04, 32'hFFFF_FFFF, 4'hF);
        wr(5'h08, 32'hFFFF_FFFF, 4'hF);
        wr(5'h10, 32'hFFFF_FFFF, 4'hF);
        wr(5'h0C, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk_i);
        #1;
        check("t4_irq_at_max", {63'h0, timer_irq_ro}, 64'h1);
        @(posedge clk_i);
        #1;
        check("t4_irq_before_wrap", {63'h0, timer_irq_ro}, 64'h1);
        @(posedge clk_i);
        #1;
        check("t4_irq_after_wrap", {63'h0, timer_irq_ro}, 64'h0);
        rd_chk("t4_mtime_lo", 5'h0C, 32'h0);
        rd_chk("t4_mtime_hi", 5'h10, 32'h0);

        // T5: MSIP bit and byte enables
        wr(5'h00, 32'h0, 4'hF);
        wr(5'h00, 32'hFFFF_FFFF, 4'h1);
        check("t5_sw_irq_latency", {63'h0, sw_irq_ro}, 64'h0);
        rd_chk("t5_msip_set", 5'h00, 32'h1);
        check("t5_sw_irq_set", {63'h0, sw_irq_ro}, 64'h1);
        wr(5'h00, 32'h0, 4'hE);
        rd_chk("t5_msip_keep", 5'h00, 32'h1);
        wr(5'h00, 32'h0, 4'h1);
        rd_chk("t5_msip_clear", 5'h00, 32'h0);
        check("t5_sw_irq_clear", {63'h0, sw_irq_ro}, 64'h0);

        // T6: four back-to-back reads give four consecutive responses
        t6_exp[0] = 32'h0;
        t6_exp[1] = 32'hFFFF_FFFF;
        t6_exp[2] = 32'hFFFF_FFFF;
        t6_exp[3] = 32'h1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            req_i  = 1'b1;
            we_i   = 1'b0;
            addr_i = (i == 3) ? 5'h14 : 5'(i * 4);
            @(posedge clk_i);
            #1;
            if (rvalid_ro) pulses++;
            check($sformatf("t6_rdata%0d", i), {32'h0, rdata_ro}, {32'h0, t6_exp[i]});
        end
        req_i  = 1'b0;
        addr_i = 5'h0;
        check("t6_pulses", 64'(pulses), 64'd4);
        @(posedge clk_i);
        #1;
        check("t6_rvalid_tail", {63'h0, rvalid_ro}, 64'h0);

        // Randomized traffic from a fresh reset
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        m_mtime = 64'h0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip  = 1'b0;
        m_presc = 0;
        m_start = 0;
        for (longint k = 0; k < 400; k++) begin
            rand_cycle(k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
